cia_wide_add_seq: RTL and testbench
===================================

Name: cia_wide_add_seq

Overview:
- Multi-cycle sequencer that computes a WORDS×SLICE-bit add or subtract by time-multiplexing one SLICE-bit carry-increment adder (CIAxbit, `size = SLICE`).
- The adder processes one word per cycle, least-significant word first, with a registered carry between slices.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.
- Trades latency for area in wide-operand datapaths.

Parameters:
- SLICE, 16, width of the shared adder slice; must match the `size` define; ≥4 and a multiple of 4.
- WORDS, 4, number of slices per operand; ≥1; total width W = SLICE*WORDS.
- IDXW, $clog2(WORDS) (min 1), width of the word-index counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept a request this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute a − b, 0 = compute a + b + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sum, cout, ovf, out_valid, busy, index, carry register and operand registers all 0.
  - in_ready=1 once rst_n deasserts.
- States:
  - IDLE: in_ready=1. On in_valid: latch a→opA and (sub ? ~b : b)→opB; carry_reg←(sub ? 1 : cin); idx←0; go to RUN.
  - RUN: busy=1, in_ready=0, and the slice adder is driven with opA word idx, opB word idx and carry_reg. Each edge:
    - sum word idx ← slice sum;
    - carry_reg ← slice cout;
    - idx←idx+1.
    - On the edge where idx==WORDS−1: cout←slice cout; ovf←(opA[W−1]==opB[W−1]) && (slice sum MSB != opA[W−1]); out_valid←1; go to DONE.
  - DONE: out_valid=1; sum, cout and ovf are held stable.
    - If out_ready=1 and in_valid=0: out_valid←0, go to IDLE.
    - If out_ready=1 and in_valid=1: accept the new request in the same cycle (same latch actions as IDLE), out_valid←0, go to RUN.
    - If out_ready=0: stay in DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready, with no other combinational input→output paths.
- Latency:
  - out_valid rises WORDS+1 rising edges after the accepting edge.
  - WORDS=1 → one RUN cycle.
  - Back-to-back throughput is one result per WORDS+1 cycles.
- Idle input handling: inputs are sampled only on an accepting edge; a, b, sub and cin may change freely during RUN/DONE.
- Result register updates: sum updates word by word during RUN. Consumers must use sum only while out_valid=1.
- Index counter: never wraps past WORDS−1; it is reset to 0 on each accept.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is emitted.
- Arithmetic: modulo 2^W. cout and ovf reflect the full W-bit operation only, never intermediate slices.

Test Plan:
- Carry ripple through all slices: WORDS=4, add, a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → after 5 edges out_valid=1, sum=0, cout=1, ovf=0.
- Subtract: sub=1, a=5, b=7 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also a=7, b=5 → sum=2, cout=1.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=64'h8000_0000_0000_0000, ovf=1, cout=0. Also a=64'h8000_0000_0000_0000, sub=1, b=1 → ovf=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE → sum, cout and ovf stable, in_ready=0.
  - Then set out_ready=1 with in_valid=1 and new operands (a=1, b=2) → same-edge accept, next out_valid after 5 edges with sum=3.
- Reset mid-operation: assert rst_n=0 two cycles into RUN → all outputs 0 immediately, in_ready=1 after release, no out_valid pulse. A subsequent request 3+4 → sum=7.
- WORDS=1 build: a=16'hFFFF, b=1 → out_valid after 2 edges, sum=0, cout=1.

Source files
------------

// File: rtl/cia_wide_add_seq.sv
// Wide add/subtract sequencer: one SLICE-bit carry-increment adder reused
// over WORDS cycles, least-significant word first, carry registered between slices.
module cia_wide_add_seq #(
  parameter int SLICE = 16,
  parameter int WORDS = 4,
  parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE*WORDS-1:0]   a,
  input  logic [SLICE*WORDS-1:0]   b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE*WORDS-1:0]   sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W  = SLICE * WORDS;
  localparam int NG = SLICE / 4;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends combinationally on out_ready only (DONE can hand off
  // the result and accept the next request on the same edge).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     opa, opb, sum_r;
  logic             carry_reg, cout_r, ovf_r;
  logic [IDXW-1:0]  idx;
  logic             accept, last;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic [NG:0]      gc;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  assign slice_a = opa[int'(idx)*SLICE +: SLICE];
  assign slice_b = opb[int'(idx)*SLICE +: SLICE];

  // Carry-increment slice: each 4-bit group adds with carry 0, then the
  // incoming group carry selects between that sum and its +1 increment.
  assign gc[0] = carry_reg;
  for (genvar g = 0; g < NG; g++) begin : g_cia
    logic [4:0] raw;
    logic [3:0] inc;
    assign raw = {1'b0, slice_a[g*4 +: 4]} + {1'b0, slice_b[g*4 +: 4]};
    assign inc = raw[3:0] + 4'd1;
    assign slice_sum[g*4 +: 4] = gc[g] ? inc : raw[3:0];
    assign gc[g+1] = gc[g] ? (raw[4] | (&raw[3:0])) : raw[4];
  end
  assign slice_cout = gc[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      sum_r     <= '0;
      carry_reg <= 1'b0;
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      // Subtract is a + ~b + 1, so the inversion and forced carry happen here.
      opa       <= a;
      opb       <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      idx       <= '0;
    end else if (state == RUN) begin
      sum_r[int'(idx)*SLICE +: SLICE] <= slice_sum;
      carry_reg <= slice_cout;
      if (last) begin
        cout_r <= slice_cout;
        ovf_r  <= (opa[W-1] == opb[W-1]) && (slice_sum[SLICE-1] != opa[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cia_wide_add_seq.sv
// Self-checking bench for cia_wide_add_seq: 64-bit (WORDS=4) and 16-bit
// (WORDS=1) instances driven with vector tables and a result scoreboard.
module tb_cia_wide_add_seq;

  localparam int SLICE = 16;
  localparam int WORDS = 4;
  localparam int W     = SLICE * WORDS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         out_valid, out_ready = 1'b0, cout, ovf, busy;

  logic         s1_in_valid = 1'b0, s1_in_ready, s1_cin = 1'b0, s1_sub = 1'b0;
  logic [15:0]  s1_a = '0, s1_b = '0, s1_sum;
  logic         s1_out_valid, s1_out_ready = 1'b0, s1_cout, s1_ovf, s1_busy;

  cia_wide_add_seq #(.SLICE(SLICE), .WORDS(WORDS)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  cia_wide_add_seq #(.SLICE(16), .WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .cin(s1_cin), .sub(s1_sub), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf), .busy(s1_busy)
  );

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   f;
    yy = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    return {f[W-1:0], f[W], (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1])};
  endfunction

  // ---------------- driver tasks ----------------
  // Present a request and hold it until the accepting edge; returns #1 after it.
  task automatic drive_req(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tc, input logic ts);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check({name, " in_ready before accept"}, {{W+1{1'b0}}, in_ready}, {{W+1{1'b0}}, 1'b1});
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: only the accepting edge may sample them.
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'(($urandom_range(0, 1))); sub = 1'(($urandom_range(0, 1)));
  endtask

  // Wait for out_valid; edges counts the accepting edge as 1.
  task automatic wait_result(input string name, input int exp_edges);
    int edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    check({name, " latency"}, (W+2)'(edges), (W+2)'(exp_edges));
  endtask

  task automatic pop_compare(input string name);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard has entry"}, '0, '1);
    end else begin
      e = exp_q.pop_front();
      check({name, " out_valid"}, {{W+1{1'b0}}, out_valid}, {{W+1{1'b0}}, 1'b1});
      check({name, " result"}, {sum, cout, ovf}, e);
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid dropped"}, {{W+1{1'b0}}, out_valid}, '0);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input logic [W+1:0] expv);
    exp_q.push_back(expv);
    drive_req(name, ta, tb_, tc, ts);
    wait_result(name, WORDS + 1);
    pop_compare(name);
    release_result(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           pulses;

    vecs[0] = '{"ripple",     64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{"sub5m7",     64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{"sub7m5",     64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[3] = '{"posovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{"negovf",     64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{"mixed",      64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[6] = '{"allones",    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{"minmin",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

    // Reset values while rst_n is held low.
    #12;
    check("reset outputs", {sum, cout, ovf}, '0);
    check("reset out_valid/busy", {{W{1'b0}}, out_valid, busy}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", {{W+1{1'b0}}, in_ready}, {{W+1{1'b0}}, 1'b1});

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].sum, vecs[i].cout, vecs[i].ovf});

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Backpressure, then a same-edge hand-off into the next request.
    exp_q.push_back({64'h8000_0000_0000_0000, 1'b0, 1'b1});
    drive_req("bp", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_result("bp", WORDS + 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d result", i), {sum, cout, ovf}, {64'h8000_0000_0000_0000, 1'b0, 1'b1});
      check($sformatf("bp hold%0d ready/valid", i), {{W{1'b0}}, in_ready, out_valid}, {{W{1'b0}}, 1'b0, 1'b1});
    end
    pop_compare("bp");
    exp_q.push_back(model(64'd1, 64'd2, 1'b0, 1'b0));
    a = 64'd1; b = 64'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b in_ready comb", {{W+1{1'b0}}, in_ready}, {{W+1{1'b0}}, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b accepted", {{W{1'b0}}, out_valid, busy}, {{W{1'b0}}, 1'b0, 1'b1});
    wait_result("b2b", WORDS + 1);
    pop_compare("b2b");
    check("b2b sum", {2'b00, sum}, {2'b00, 64'd3});
    release_result("b2b");

    // Reset two cycles into RUN: partial result discarded, no out_valid pulse.
    drive_req("rst", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun reset result", {sum, cout, ovf}, '0);
    check("midrun reset valid/busy", {{W{1'b0}}, out_valid, busy}, '0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("in_ready after midrun reset", {{W+1{1'b0}}, in_ready}, {{W+1{1'b0}}, 1'b1});
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) pulses++;
    end
    check("no pulse after reset", (W+2)'(pulses), '0);
    run_op("after reset 3+4", 64'd3, 64'd4, 1'b0, 1'b0, {64'd7, 1'b0, 1'b0});

    // WORDS=1 instance: one RUN cycle.
    begin
      logic [15:0] t1a[3], t1b[3];
      logic        t1s[3];
      logic [17:0] t1e[3];
      int          edges;
      t1a[0] = 16'hFFFF; t1b[0] = 16'h0001; t1s[0] = 1'b0; t1e[0] = {16'h0000, 1'b1, 1'b0};
      t1a[1] = 16'h7FFF; t1b[1] = 16'h0001; t1s[1] = 1'b0; t1e[1] = {16'h8000, 1'b0, 1'b1};
      t1a[2] = 16'h0000; t1b[2] = 16'h0001; t1s[2] = 1'b1; t1e[2] = {16'hFFFF, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
        s1_a = t1a[i]; s1_b = t1b[i]; s1_sub = t1s[i]; s1_cin = 1'b0; s1_in_valid = 1'b1;
        #1;
        check($sformatf("w1 vec%0d in_ready", i), {{W+1{1'b0}}, s1_in_ready}, {{W+1{1'b0}}, 1'b1});
        @(posedge clk); #1;
        s1_in_valid = 1'b0; s1_a = 16'h1234; s1_b = 16'h4321;
        edges = 1;
        while (!s1_out_valid && edges < 20) begin
          @(posedge clk); #1; edges++;
        end
        check($sformatf("w1 vec%0d latency", i), (W+2)'(edges), (W+2)'(2));
        check($sformatf("w1 vec%0d result", i), {48'h0, s1_sum, s1_cout, s1_ovf}, {48'h0, t1e[i]});
        s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_out_ready = 1'b0;
      end
    end

    check("scoreboard drained", (W+2)'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
